pc_update_unit: RTL and testbench
=================================

// Module: pc_update_unit
// PURPOSE
//   Program-counter stage fed by the PC-source mux (6:1, 32-bit). Holds PC and EPC.
//   Commits the mux output on an unconditional or branch-qualified write.
//   On an exception, saves EPC and the cause, then fetches the handler address byte from memory.
//   It then loads PC with that byte, zero-extended. busy stalls the main control FSM meanwhile.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC value after reset
//   VEC_OPCODE  32'd253        memory byte address of the invalid-opcode handler pointer
//   VEC_OVF     32'd254        memory byte address of the overflow handler pointer
//   VEC_DIV0    32'd255        memory byte address of the divide-by-zero handler pointer
// PORTS
//   clk            in   1   rising-edge clock
//   reset_n        in   1   asynchronous, active-low reset
//   next_pc        in   32  PC-source mux output
//   pc_write       in   1   unconditional PC write
//   pc_write_cond  in   1   conditional PC write (branch)
//   branch_type    in   2   00 beq, 01 bne, 10 ble, 11 bgt
//   alu_zero       in   1   ALU zero flag
//   alu_gt         in   1   ALU greater-than flag (signed A>B)
//   exc_req        in   1   exception request, sampled only in IDLE
//   exc_cause      in   2   00 none, 01 invalid opcode, 10 overflow, 11 div by zero
//   vec_valid      in   1   memory returns the vector byte
//   vec_data       in   8   vector byte
//   pc             out  32  current PC
//   epc            out  32  saved exception PC
//   cause          out  2   latched exception cause
//   vec_req        out  1   vector read request
//   vec_addr       out  32  vector byte address
//   busy           out  1   exception sequence in progress
//   exc_done       out  1   one-cycle pulse when the handler PC is loaded
// BEHAVIOUR
//   Reset (async, reset_n=0): pc=RESET_PC, epc=0, cause=0, state=IDLE, vec_addr=0.
//     All 1-bit outputs are 0. Takes effect mid-sequence too; any pending vector read is abandoned.
//   cond: beq=alu_zero, bne=!alu_zero, ble=!alu_gt, bgt=alu_gt.
//   take = pc_write | (pc_write_cond & cond). Evaluated only in IDLE.
//   FSM states: IDLE, VEC_REQ, RESUME.
//   IDLE:
//     exc_req=1 and exc_cause!=0 -> exception accepted:
//       epc <= pc - 4 (mod 2^32); cause <= exc_cause; vec_addr <= vector for cause.
//       Next state is VEC_REQ.
//       Any take in the same cycle is suppressed; the exception wins.
//     Otherwise, if take: pc <= next_pc.
//     exc_req with exc_cause=00 is ignored; the normal take still applies.
//   VEC_REQ:
//     vec_req=1 (decoded from state); vec_addr held stable.
//     Waits indefinitely for vec_valid.
//     On vec_valid: pc <= {24'b0, vec_data}; next state is RESUME.
//     pc_write, pc_write_cond and exc_req are ignored.
//   RESUME:
//     exc_done=1 for exactly one cycle; next state is IDLE.
//     Inputs are ignored.
//   busy = (state != IDLE), decoded combinationally.
//   Accept at edge N: busy high from N through the RESUME cycle, low the cycle after.
//   epc and cause hold until the next accepted exception. A nested exc_req while busy is dropped.
//   All arithmetic is 32-bit unsigned wrap: pc=0 gives epc=32'hFFFF_FFFC.
//   vec_valid outside VEC_REQ is ignored.
// TESTING
//   Reset at pc=0x40 mid-VEC_REQ -> pc=0, state IDLE, vec_req=0, busy=0 immediately (async).
//   pc=0x10, pc_write=1, next_pc=0x14 -> pc=0x14 next cycle. pc_write=0, cond=0 -> pc holds.
//   Branch cases with next_pc=0x80:
//     beq, zero=1 -> pc=0x80.
//     bne, zero=1 -> pc holds.
//     bgt, gt=1 -> pc=0x80.
//     ble, gt=1 -> pc holds.
//   pc=0x24, exc_req=1, cause=10, pc_write=1 same cycle:
//     -> epc=0x20, cause=10, pc unchanged, vec_addr=254, vec_req=1.
//     vec_valid after 3 cycles, vec_data=0x9C -> pc=0x0000_009C, exc_done pulse, busy low next cycle.
//   While busy: exc_req=1 cause=01 and pc_write=1 -> epc, cause and pc are unaffected until vec_valid.
//   pc=0 with cause=11 -> epc=0xFFFF_FFFC, vec_addr=255.
//   exc_req with cause=00 and pc_write=1 -> normal PC write, busy stays 0.

Source files
------------

// File: rtl/pc_update_unit.sv
// Program counter stage: PC/EPC registers, branch-qualified writes
// and a small exception sequencer that fetches a handler byte.
module pc_update_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] VEC_OPCODE = 32'd253,
  parameter logic [31:0] VEC_OVF    = 32'd254,
  parameter logic [31:0] VEC_DIV0   = 32'd255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] next_pc,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_type,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic        exc_req,
  input  logic [1:0]  exc_cause,
  input  logic        vec_valid,
  input  logic [7:0]  vec_data,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        vec_req,
  output logic [31:0] vec_addr,
  output logic        busy,
  output logic        exc_done
);

  typedef enum logic [1:0] {
    IDLE,
    VEC_REQ,
    RESUME
  } state_t;

  state_t      state;
  logic        cond;
  logic        take;
  logic        exc_ok;
  logic [31:0] vec_sel;

  // Branch condition from the ALU flags
  always_comb begin
    cond = 1'b0;
    unique case (branch_type)
      2'b00: cond = alu_zero;
      2'b01: cond = !alu_zero;
      2'b10: cond = !alu_gt;
      2'b11: cond = alu_gt;
    endcase
  end

  // Handler pointer address for the requested cause
  always_comb begin
    vec_sel = VEC_OPCODE;
    unique case (exc_cause)
      2'b01:   vec_sel = VEC_OPCODE;
      2'b10:   vec_sel = VEC_OVF;
      2'b11:   vec_sel = VEC_DIV0;
      default: vec_sel = VEC_OPCODE;
    endcase
  end

  assign take   = pc_write | (pc_write_cond & cond);
  assign exc_ok = exc_req & (exc_cause != 2'b00);

  // Sequencer plus PC/EPC/cause/vector-address registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      epc      <= 32'h0;
      cause    <= 2'b00;
      vec_addr <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (exc_ok) begin
            epc      <= pc - 32'd4;
            cause    <= exc_cause;
            vec_addr <= vec_sel;
            state    <= VEC_REQ;
          end else if (take) begin
            pc <= next_pc;
          end
        end
        VEC_REQ: begin
          if (vec_valid) begin
            pc    <= {24'b0, vec_data};
            state <= RESUME;
          end
        end
        RESUME: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign vec_req  = (state == VEC_REQ);
  assign exc_done = (state == RESUME);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_pc_update_unit.sv
// Bench for pc_update_unit: directed scenarios then random
// traffic, all checked against a behavioural model.
module tb_pc_update_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] next_pc;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_type;
  logic        alu_zero;
  logic        alu_gt;
  logic        exc_req;
  logic [1:0]  exc_cause;
  logic        vec_valid;
  logic [7:0]  vec_data;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic        vec_req;
  logic [31:0] vec_addr;
  logic        busy;
  logic        exc_done;

  int total = 0;
  int bad   = 0;

  // model: phase 0 idle, 1 awaiting vector byte, 2 resume
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [1:0]  m_cause;
  logic [31:0] m_vaddr;

  pc_update_unit dut (
    .clk(clk),
    .reset_n(reset_n),
    .next_pc(next_pc),
    .pc_write(pc_write),
    .pc_write_cond(pc_write_cond),
    .branch_type(branch_type),
    .alu_zero(alu_zero),
    .alu_gt(alu_gt),
    .exc_req(exc_req),
    .exc_cause(exc_cause),
    .vec_valid(vec_valid),
    .vec_data(vec_data),
    .pc(pc),
    .epc(epc),
    .cause(cause),
    .vec_req(vec_req),
    .vec_addr(vec_addr),
    .busy(busy),
    .exc_done(exc_done)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    next_pc       = 32'h0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_type   = 2'b00;
    alu_zero      = 1'b0;
    alu_gt        = 1'b0;
    exc_req       = 1'b0;
    exc_cause     = 2'b00;
    vec_valid     = 1'b0;
    vec_data      = 8'h00;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc    = 32'h0;
    m_epc   = 32'h0;
    m_cause = 2'b00;
    m_vaddr = 32'h0;
  endtask

  function automatic bit branch_ok();
    bit [3:0] tbl;
    tbl = {alu_gt, !alu_gt, !alu_zero, alu_zero};
    return tbl[branch_type];
  endfunction

  task automatic model_edge();
    case (m_phase)
      0: begin
        if (exc_req && exc_cause != 0) begin
          m_epc   = m_pc - 32'd4;
          m_cause = exc_cause;
          m_vaddr = 32'd252 + 32'(exc_cause);
          m_phase = 1;
        end else if (pc_write
                     || (pc_write_cond && branch_ok())) begin
          m_pc = next_pc;
        end
      end
      1: begin
        if (vec_valid) begin
          m_pc    = 32'(vec_data);
          m_phase = 2;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_all(string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".epc"}, epc, m_epc);
    chk({tag, ".cause"}, 32'(cause), 32'(m_cause));
    chk({tag, ".vaddr"}, vec_addr, m_vaddr);
    chk({tag, ".busy"}, 32'(busy), 32'(m_phase != 0));
    chk({tag, ".vreq"}, 32'(vec_req), 32'(m_phase == 1));
    chk({tag, ".done"}, 32'(exc_done),
        32'(m_phase == 2));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    idle_inputs();
  endtask

  task automatic set_pc(logic [31:0] v);
    next_pc  = v;
    pc_write = 1'b1;
    tick("setpc");
  endtask

  task automatic branch(logic [1:0] bt, logic z,
                        logic g, string tag);
    next_pc       = 32'h80;
    pc_write_cond = 1'b1;
    branch_type   = bt;
    alu_zero      = z;
    alu_gt        = g;
    tick(tag);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    set_pc(32'h10);
    next_pc  = 32'h14;
    pc_write = 1'b1;
    tick("write");
    chk("write14", pc, 32'h14);
    tick("hold");
    chk("hold14", pc, 32'h14);

    set_pc(32'h10);
    branch(2'b00, 1'b1, 1'b0, "beq");
    chk("beq_taken", pc, 32'h80);
    set_pc(32'h10);
    branch(2'b01, 1'b1, 1'b0, "bne");
    chk("bne_held", pc, 32'h10);
    branch(2'b11, 1'b0, 1'b1, "bgt");
    chk("bgt_taken", pc, 32'h80);
    set_pc(32'h10);
    branch(2'b10, 1'b0, 1'b1, "ble");
    chk("ble_held", pc, 32'h10);

    set_pc(32'h24);
    exc_req   = 1'b1;
    exc_cause = 2'b10;
    pc_write  = 1'b1;
    next_pc   = 32'h1234;
    tick("exc_ovf");
    chk("ovf_epc", epc, 32'h20);
    chk("ovf_pc", pc, 32'h24);
    chk("ovf_vaddr", vec_addr, 32'd254);
    for (int i = 0; i < 3; i++) begin
      exc_req   = 1'b1;
      exc_cause = 2'b01;
      pc_write  = 1'b1;
      next_pc   = 32'h5555;
      tick("nested");
    end
    vec_valid = 1'b1;
    vec_data  = 8'h9C;
    tick("vec");
    chk("vec_pc", pc, 32'h9C);
    chk("vec_done", 32'(exc_done), 32'd1);
    tick("resume");
    chk("resume_busy", 32'(busy), 32'd0);

    set_pc(32'h0);
    exc_req   = 1'b1;
    exc_cause = 2'b11;
    tick("exc_div0");
    chk("div0_epc", epc, 32'hFFFF_FFFC);
    chk("div0_vaddr", vec_addr, 32'd255);
    vec_valid = 1'b1;
    vec_data  = 8'h3A;
    tick("vec2");
    tick("resume2");

    exc_req   = 1'b1;
    exc_cause = 2'b00;
    pc_write  = 1'b1;
    next_pc   = 32'h44;
    tick("cause0");
    chk("cause0_busy", 32'(busy), 32'd0);
    vec_valid = 1'b1;
    vec_data  = 8'hEE;
    tick("stray_vec");

    set_pc(32'h40);
    exc_req   = 1'b1;
    exc_cause = 2'b01;
    tick("exc_op");
    tick("wait");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      next_pc       = $urandom;
      pc_write      = ($urandom_range(0, 3) == 0);
      pc_write_cond = $urandom_range(0, 1) == 1;
      branch_type   = 2'($urandom_range(0, 3));
      alu_zero      = $urandom_range(0, 1) == 1;
      alu_gt        = $urandom_range(0, 1) == 1;
      exc_req       = ($urandom_range(0, 7) == 0);
      exc_cause     = 2'($urandom_range(0, 3));
      vec_valid     = ($urandom_range(0, 2) == 0);
      vec_data      = 8'($urandom);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
